mult_seq_nbits: RTL and testbench

Parametrised sequential shift-add multiplier, successor to the fixed 4-bit shift-add multiplier.
- Operand width is set by parameter; product width is 2*WIDTH.
- Supports unsigned and two's-complement signed operands, selected per operation.
- Uses a start/busy/done handshake, and the product is held stable until the next accepted start.
- Sits between a control FSM or host and the datapath that consumes products.

---
 rtl/mult_pkg.sv | 37 +++
 rtl/mult_seq_ctrl.sv | 67 ++++++
 rtl/mult_seq_nbits.sv | 117 +++++++++++
 tb/tb_mult_seq_nbits.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Latency: none (types and a combinational helper only).
// Backpressure: none.
package mult_pkg;

  // Controller states: wait for start, iterate, then present the result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_END  = 2'd2
  } mult_state_t;

  // Widest operand the helper below handles.
  localparam int unsigned MAX_W = 32;

  // Conditional two's-complement magnitude of the low w bits of val.
  // The result is confined to w bits. This keeps the magnitude of the most
  // negative value, 2^(w-1), representable as an unsigned w-bit number.
  function automatic logic [MAX_W-1:0] abs_w(
    input logic [MAX_W-1:0] val,
    input int unsigned      w,
    input logic             is_signed
  );
    logic [MAX_W-1:0] mask;
    logic [4:0]       msb_idx;
    logic             msb;
    mask    = (w >= MAX_W) ? {MAX_W{1'b1}} : ((32'd1 << w) - 32'd1);
    msb_idx = 5'(w - 1);
    msb     = val[msb_idx];
    if (is_signed && msb) begin
      abs_w = (~val + 32'd1) & mask;
    end else begin
      abs_w = val & mask;
    end
  endfunction

endpackage

// File: rtl/mult_seq_ctrl.sv
// Control FSM and iteration counter for the shift-add multiplier.
// Latency: an accepted start reaches ST_END WIDTH edges after the accept edge.
// Backpressure: start_i is only looked at in ST_IDLE and is dropped elsewhere.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output mult_state_t state_o,
  output logic        last_iter_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mult_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next state and counter. The counter is cleared on accept and counts the
  // iterations already performed. It therefore reads WIDTH on entry to ST_END.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_CALC;
          cnt_d   = '0;
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_END;
        end
      end
      ST_END: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers; reset wins in any state, even mid-operation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Flags the iteration whose edge also moves the FSM into ST_END.
  always_comb begin
    state_o     = state_q;
    last_iter_o = (state_q == ST_CALC) && (cnt_q == LAST_CNT);
  end

endmodule

// File: rtl/mult_seq_nbits.sv
// Parametrised sequential shift-add multiplier, unsigned or signed per operation.
// Latency: fixed WIDTH+1 cycles from the start cycle to done_o. Throughput is one result per WIDTH+2 cycles.
// Backpressure: start_i is ignored while busy_o is high. Nothing is queued.
module mult_seq_nbits
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               ready_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int PW = 2 * WIDTH;

  mult_state_t state;
  logic        last_iter;

  mult_seq_ctrl #(
    .WIDTH (WIDTH)
  ) u_ctrl (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .state_o     (state),
    .last_iter_o (last_iter)
  );

  // Datapath state: shifted multiplicand, multiplier, accumulator, sign, result.
  logic [PW-1:0]    a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic             sign_neg_q, sign_neg_d;
  logic [PW-1:0]    prod_q, prod_d;

  logic [MAX_W-1:0] a_abs_full, b_abs_full;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             unused_abs_bits;
  logic             accept;
  logic [PW-1:0]    add_term;
  logic [PW-1:0]    acc_sum;

  // Operand magnitudes. The multiply runs on magnitudes and the sign is
  // applied once at the end, so signed and unsigned share one datapath.
  always_comb begin
    a_abs_full      = abs_w(MAX_W'(a_i), WIDTH, signed_i);
    b_abs_full      = abs_w(MAX_W'(b_i), WIDTH, signed_i);
    a_mag           = a_abs_full[WIDTH-1:0];
    b_mag           = b_abs_full[WIDTH-1:0];
    unused_abs_bits = ^{a_abs_full, b_abs_full};
  end

  // One iteration: add the shifted multiplicand when the multiplier LSB is set.
  // The sum feeds both the accumulator and, on the last iteration, the result.
  always_comb begin
    accept   = (state == ST_IDLE) && start_i;
    add_term = b_q[0] ? a_q : '0;
    acc_sum  = acc_q + add_term;
  end

  // Datapath next-state: load on accept, shift-add in ST_CALC, else hold.
  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    sign_neg_d = sign_neg_q;
    prod_d     = prod_q;
    if (accept) begin
      a_d        = PW'(a_mag);
      b_d        = b_mag;
      acc_d      = '0;
      sign_neg_d = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
    end else if (state == ST_CALC) begin
      acc_d = acc_sum;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      // The result register is written only here. It holds through ST_IDLE
      // until the next operation finishes or a reset clears it.
      if (last_iter) begin
        prod_d = sign_neg_q ? (-acc_sum) : acc_sum;
      end
    end
  end

  // Datapath registers; everything resets so no X can reach product_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      sign_neg_q <= 1'b0;
      prod_q     <= '0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      sign_neg_q <= sign_neg_d;
      prod_q     <= prod_d;
    end
  end

  // Handshake outputs decode directly from the controller state.
  always_comb begin
    ready_o   = (state == ST_IDLE);
    busy_o    = (state == ST_CALC) || (state == ST_END);
    done_o    = (state == ST_END);
    product_o = prod_q;
  end

endmodule

// File: tb/tb_mult_seq_nbits.sv
// Directed bench for mult_seq_nbits at WIDTH 4, 8 and 16 with a result scoreboard.
// Expected products are queued when an operation is started and popped at done_o.
// A reference model covers the operations that use random operands.
module tb_mult_seq_nbits;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start4 = 0, sgn4 = 0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        ready4, busy4, done4;
  logic [7:0]  prod4;

  logic        start8 = 0, sgn8 = 0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ready8, busy8, done8;
  logic [15:0] prod8;

  logic        start16 = 0, sgn16 = 0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ready16, busy16, done16;
  logic [31:0] prod16;

  mult_seq_nbits #(.WIDTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start4), .signed_i(sgn4), .a_i(a4), .b_i(b4),
    .ready_o(ready4), .busy_o(busy4), .done_o(done4), .product_o(prod4));
  mult_seq_nbits #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .signed_i(sgn8), .a_i(a8), .b_i(b8),
    .ready_o(ready8), .busy_o(busy8), .done_o(done8), .product_o(prod8));
  mult_seq_nbits #(.WIDTH(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .start_i(start16), .signed_i(sgn16), .a_i(a16), .b_i(b16),
    .ready_o(ready16), .busy_o(busy16), .done_o(done16), .product_o(prod16));

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pop_exp();
    if (exp_q.size() == 0) return 64'hDEAD_DEAD_DEAD_DEAD;
    return exp_q.pop_front();
  endfunction

  // Reference: sign-extend each w-bit operand if signed, multiply, keep 2w bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input int w, input bit s);
    logic [63:0] msk, ua, ub;
    longint      p;
    msk = (64'd1 << w) - 64'd1;
    ua  = {32'd0, a} & msk;
    ub  = {32'd0, b} & msk;
    if (s && ua[w-1]) ua = ua - (64'd1 << w);
    if (s && ub[w-1]) ub = ub - (64'd1 << w);
    p = longint'(ua) * longint'(ub);
    return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  task automatic drive(input int which, input bit st, input logic [31:0] a,
                       input logic [31:0] b, input bit s);
    case (which)
      4:  begin start4  = st; a4  = a[3:0];  b4  = b[3:0];  sgn4  = s; end
      8:  begin start8  = st; a8  = a[7:0];  b8  = b[7:0];  sgn8  = s; end
      16: begin start16 = st; a16 = a[15:0]; b16 = b[15:0]; sgn16 = s; end
      default: ;
    endcase
  endtask

  function automatic bit done_of(input int which);
    case (which)
      4: return done4; 8: return done8; default: return done16;
    endcase
  endfunction
  function automatic bit ready_of(input int which);
    case (which)
      4: return ready4; 8: return ready8; default: return ready16;
    endcase
  endfunction
  function automatic bit busy_of(input int which);
    case (which)
      4: return busy4; 8: return busy8; default: return busy16;
    endcase
  endfunction
  function automatic logic [63:0] prod_of(input int which);
    case (which)
      4: return {56'd0, prod4}; 8: return {48'd0, prod8}; default: return {32'd0, prod16};
    endcase
  endfunction

  // One operation: start for one cycle, scramble operands while busy, then
  // check latency, product, the single-cycle done pulse and the return to idle.
  task automatic run_op(input int which, input logic [31:0] a, input logic [31:0] b,
                        input bit s, input logic [63:0] exp);
    int lat;
    @(negedge clk);
    drive(which, 1, a, b, s);
    exp_q.push_back(exp);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) drive(which, 0, $urandom, $urandom, 1'($urandom));
    end while (!done_of(which) && lat < 40);
    check($sformatf("w%0d_latency", which), 64'(lat), 64'(which + 1));
    check($sformatf("w%0d_product", which), prod_of(which), pop_exp());
    check($sformatf("w%0d_busy_in_end", which), 64'(busy_of(which)), 64'd1);
    @(negedge clk);
    check($sformatf("w%0d_done_one_cycle", which), 64'(done_of(which)), 64'd0);
    check($sformatf("w%0d_ready_after_done", which), 64'(ready_of(which)), 64'd1);
  endtask

  initial begin
    int seen, ndone, last;
    logic [31:0] ra, rb;
    bit rs;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_prod8", {48'd0, prod8}, 64'd0);
    check("rst_ready8", 64'(ready8), 64'd1);
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_prod16", {32'd0, prod16}, 64'd0);
    rst = 1'b0;

    // Unsigned and signed directed cases at WIDTH=8.
    run_op(8, 32'd13, 32'd11, 0, 64'h008F);
    repeat (5) begin
      @(negedge clk);
      drive(8, 0, $urandom, $urandom, 1);
    end
    check("hold_idle", {48'd0, prod8}, 64'h008F);
    run_op(8, 32'hFD, 32'h05, 1, 64'hFFF1);
    run_op(8, 32'h80, 32'h80, 1, 64'h4000);
    run_op(8, 32'h80, 32'h7F, 1, 64'hC080);
    run_op(8, 32'hFF, 32'hFF, 0, 64'hFE01);
    run_op(8, 32'h00, 32'hAA, 0, 64'h0000);
    run_op(8, 32'hFF, 32'hFF, 1, 64'h0001);

    // Starts while busy are ignored; the first operands win.
    @(negedge clk);
    drive(8, 1, 32'd7, 32'd9, 0);
    exp_q.push_back(64'd63);
    seen = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 3 || i == 6) drive(8, 1, 32'hFF, 32'hFF, 0);
      else drive(8, 0, 32'h11, 32'h22, 0);
      if (done8 && seen == 0) seen = i;
    end
    check("ign_latency", 64'(seen), 64'd9);
    check("ign_product", {48'd0, prod8}, pop_exp());
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("ign_no_queued_op", 64'(ndone), 64'd0);

    // Start held high: a done every WIDTH+2 cycles.
    @(negedge clk);
    drive(8, 1, 32'd5, 32'd6, 0);
    exp_q.push_back(64'd30);
    ndone = 0;
    last  = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done8) begin
        ndone++;
        if (ndone > 1) check("b2b_gap", 64'(i - last), 64'd10);
        else check("b2b_first", 64'(i), 64'd9);
        last = i;
        check("b2b_product", {48'd0, prod8}, pop_exp());
      end
      if (ready8 && i < 30) exp_q.push_back(64'd30);
    end
    drive(8, 0, 32'd0, 32'd0, 0);
    check("b2b_count", 64'(ndone), 64'd3);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("b2b_drain", 64'(ndone), 64'd0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset during the fourth iteration.
    @(negedge clk);
    drive(8, 1, 32'h55, 32'h33, 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      drive(8, 0, 32'h55, 32'h33, 0);
    end
    #2 rst = 1'b1;
    #1;
    check("arst_prod", {48'd0, prod8}, 64'd0);
    check("arst_busy", 64'(busy8), 64'd0);
    check("arst_ready", 64'(ready8), 64'd1);
    check("arst_done", 64'(done8), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("arst_no_done", 64'(ndone), 64'd0);
    run_op(8, 32'd13, 32'd11, 0, 64'h008F);

    // Other widths.
    run_op(4, 32'hF, 32'hF, 0, 64'hE1);
    run_op(4, 32'h8, 32'h8, 1, 64'h40);
    run_op(16, 32'h8000, 32'h8000, 1, 64'h4000_0000);
    run_op(16, 32'hFFFF, 32'hFFFF, 0, 64'hFFFE_0001);

    // Random operands against the reference model.
    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom);
      run_op(8, ra, rb, rs, ref_mul(ra, rb, 8, rs));
      ra = $urandom; rb = $urandom; rs = 1'($urandom);
      run_op(16, ra, rb, rs, ref_mul(ra, rb, 16, rs));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
